// File: rtl/req_arbiter4_pkg.sv
// Shared types and defaults for the four-way request arbiter.
// Imported by the picker and the arbiter top.
package req_arbiter4_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int DEF_HOLD_W   = 4;
    localparam int DEF_MAX_HOLD = 15;

    function automatic logic [3:0] idx2oh(
        input logic [1:0] i
    );
        return 4'b0001 << i;
    endfunction

endpackage

// File: rtl/req_arbiter4_if.sv
// Request/grant bundle between the clients and the arbiter.
// master = client side, slave = arbiter side.
interface req_arbiter4_if;

    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        input  grant,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/req_arbiter4_prio_pick4.sv
// Combinational rotating priority picker for four requesters.
// rr_en=0 ignores start and returns the highest set index.
module prio_pick4
    import req_arbiter4_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] start,
    input  logic       rr_en,
    output logic       any,
    output logic [1:0] idx,
    output logic [3:0] onehot
);

    logic       found;
    logic [1:0] pos;

    always_comb begin
        idx   = 2'd0;
        found = 1'b0;
        pos   = 2'd0;
        if (rr_en) begin
            for (int k = 0; k < 4; k++) begin
                pos = start + 2'(k);
                if (!found && req[pos]) begin
                    idx   = pos;
                    found = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (req[k]) begin
                    idx = 2'(k);
                end
            end
        end
        any    = |req;
        onehot = any ? idx2oh(idx) : 4'b0000;
    end

endmodule

// File: rtl/req_arbiter4.sv
// Four-requester arbiter with registered one-hot grant,
// round-robin or fixed priority, and a hold timeout.
module req_arbiter4
    import req_arbiter4_pkg::*;
#(
    parameter bit RR_EN    = 1'b1,
    parameter int HOLD_W   = DEF_HOLD_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst_n,
    req_arbiter4_if.slave  bus
);

    localparam bit TO_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LIM =
        HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              tout_q, tout_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        last_q, last_d;
    logic [3:0]        excl_q, excl_d;

    logic [3:0] cand;
    logic [1:0] start;
    logic       p_any;
    logic [1:0] p_idx;
    logic [3:0] p_oh;

    assign cand  = bus.req & ~excl_q;
    assign start = last_q + 2'd1;

    prio_pick4 u_pick (
        .req    (cand),
        .start  (start),
        .rr_en  (RR_EN),
        .any    (p_any),
        .idx    (p_idx),
        .onehot (p_oh)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        tout_d  = 1'b0;
        hold_d  = hold_q;
        last_d  = last_q;
        excl_d  = excl_q;
        unique case (state_q)
            IDLE: begin
                excl_d  = 4'b0000;
                grant_d = 4'b0000;
                valid_d = 1'b0;
                if (p_any) begin
                    grant_d = p_oh;
                    idx_d   = p_idx;
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!(&hold_q)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (!bus.req[idx_q]) begin
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                    state_d = RELEASE;
                end else if (TO_EN && hold_q == HOLD_LIM) begin
                    // Bar the owner from the very next arbitration only.
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                    tout_d  = 1'b1;
                    excl_d  = idx2oh(idx_q);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                grant_d = 4'b0000;
                valid_d = 1'b0;
                last_d  = idx_q;
                state_d = IDLE;
            end
            default: begin
                grant_d = 4'b0000;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
            hold_q  <= '0;
            last_q  <= 2'd3;
            excl_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            excl_q  <= excl_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = tout_q;

endmodule
